vai_tx_auditor: RTL and testbench

- Per-sub-AFU Tx-path stage between one sub-AFU's CCI-P Tx port and the VAI mux Tx input.
- Relocates c0 read and c1 write cache-line addresses by the manager-programmed per-VM offset, which is one `offset_array` entry.
- Drops traffic while the VM's `sub_afu_reset` bit is set, and drops requests whose relocated address overflows.
- Counts dropped requests and passes c2 MMIO responses through, all with fixed latency.

---
 rtl/vai_tx_auditor.sv | 242 ++++++++++++++++++++++++
 tb/tb_vai_tx_auditor.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vai_tx_auditor.sv
// vai_tx_auditor: per-sub-AFU Tx-path stage between one sub-AFU's CCI-P Tx
// port and the VAI mux Tx input.
//   - c0 reads and c1 writes are relocated by this VM's cache-line offset.
//     Their fixed latency is 2 cycles.
//   - Requests are dropped while the VM is held in sub_reset.
//   - Requests whose relocated address overflows 42 bits are also dropped.
//   - c2 MMIO read responses are forwarded with a fixed latency of 1 cycle.
//
// Ports:
//   clk        CCI-P primary clock
//   reset      synchronous, active-high reset
//   offset     cache-line offset for this VM (bits [41:0] used)
//   sub_reset  this VM's sub_afu_reset bit
//   in_c0/1/2  sub-AFU Tx channels (read req, write/fence req, MMIO rsp)
//   out_c0/1/2 Tx channels towards the VAI mux
//   drop_count saturating count of dropped c0+c1 requests
//   ovf_err    sticky address-overflow flag
//   vmid_out   constant VMID of this sub-AFU

package vai_tx_auditor_pkg;
  localparam logic [3:0] eREQ_RDLINE_I = 4'h0;
  localparam logic [3:0] eREQ_RDLINE_S = 4'h1;
  localparam logic [3:0] eREQ_WRLINE_I = 4'h0;
  localparam logic [3:0] eREQ_WRLINE_M = 4'h1;
  localparam logic [3:0] eREQ_WRFENCE  = 4'h4;

  typedef struct packed {
    logic [1:0]  vc_sel;
    logic [1:0]  rsvd1;
    logic [1:0]  cl_len;
    logic [3:0]  req_type;
    logic [5:0]  rsvd0;
    logic [41:0] address;
    logic [15:0] mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    logic [5:0]  rsvd2;
    logic [1:0]  vc_sel;
    logic        sop;
    logic        rsvd1;
    logic [1:0]  cl_len;
    logic [3:0]  req_type;
    logic [5:0]  rsvd0;
    logic [41:0] address;
    logic [15:0] mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    logic [8:0] tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    logic [511:0]       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    logic [63:0]         data;
  } t_if_ccip_c2_Tx;
endpackage

module vai_tx_auditor
  import vai_tx_auditor_pkg::*;
#(
  parameter int VMID      = 0,
  parameter int CNT_WIDTH = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [63:0]                         offset,
  input  logic                                sub_reset,
  input  vai_tx_auditor_pkg::t_if_ccip_c0_Tx  in_c0,
  input  vai_tx_auditor_pkg::t_if_ccip_c1_Tx  in_c1,
  input  vai_tx_auditor_pkg::t_if_ccip_c2_Tx  in_c2,
  output vai_tx_auditor_pkg::t_if_ccip_c0_Tx  out_c0,
  output vai_tx_auditor_pkg::t_if_ccip_c1_Tx  out_c1,
  output vai_tx_auditor_pkg::t_if_ccip_c2_Tx  out_c2,
  output logic [CNT_WIDTH-1:0]                drop_count,
  output logic                                ovf_err,
  output logic [7:0]                          vmid_out
);

  typedef enum logic {S_RUN = 1'b0, S_HOLD = 1'b1} state_t;

  // 43-bit relocation sum; bit 42 is the overflow carry.
  function automatic logic [42:0] reloc(input logic [41:0] addr, input logic [41:0] off);
    return {1'b0, addr} + {1'b0, off};
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [1:0]           b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + {{(CNT_WIDTH-1){1'b0}}, b};
    return s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
  endfunction

  state_t state_q, state_d;
  logic   hold_t0;

  logic                c0_vld_p1_q, c0_drop_p1_q, c1_vld_p1_q, c1_drop_p1_q;
  t_ccip_c0_ReqMemHdr  c0_hdr_p1_q;
  t_ccip_c1_ReqMemHdr  c1_hdr_p1_q;
  logic [511:0]        c1_data_p1_q;

  logic [42:0]         c0_sum, c1_sum;
  logic                c0_carry, c1_carry, c1_fence;
  logic                c0_live, c1_live, c0_fwd, c1_fwd;
  logic                c0_ovf, c1_ovf, c0_drop, c1_drop;
  logic [1:0]          drop_inc;
  t_ccip_c0_ReqMemHdr  c0_hdr_reloc;
  t_ccip_c1_ReqMemHdr  c1_hdr_reloc;

  logic                c0_vld_p2_q, c1_vld_p2_q;
  t_ccip_c0_ReqMemHdr  c0_hdr_p2_q;
  t_ccip_c1_ReqMemHdr  c1_hdr_p2_q;
  logic [511:0]        c1_data_p2_q;

  logic                c2_vld_p1_q;
  t_ccip_c2_RspMmioHdr c2_hdr_p1_q;
  logic [63:0]         c2_data_p1_q;

  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 ovf_q;

  logic unused_offset_hi;
  assign unused_offset_hi = ^offset[63:42];

  // The hold decision uses the next state, so a request is dropped in the
  // same T0 cycle in which sub_reset is first seen high. The first request
  // after sub_reset falls is passed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (sub_reset)  state_d = S_HOLD;
      S_HOLD:  if (!sub_reset) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
    hold_t0 = (state_d == S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_RUN;
    else       state_q <= state_d;
  end

  // ---- T0 -> T1 ----
  always_ff @(posedge clk) begin
    if (reset) begin
      c0_vld_p1_q  <= 1'b0;
      c0_drop_p1_q <= 1'b0;
      c1_vld_p1_q  <= 1'b0;
      c1_drop_p1_q <= 1'b0;
      c2_vld_p1_q  <= 1'b0;
    end else begin
      c0_vld_p1_q  <= in_c0.valid;
      c0_drop_p1_q <= hold_t0;
      c1_vld_p1_q  <= in_c1.valid;
      c1_drop_p1_q <= hold_t0;
      c2_vld_p1_q  <= in_c2.mmioRdValid;
    end
  end

  always_ff @(posedge clk) begin
    c0_hdr_p1_q  <= in_c0.hdr;
    c1_hdr_p1_q  <= in_c1.hdr;
    c1_data_p1_q <= in_c1.data;
    c2_hdr_p1_q  <= in_c2.hdr;
    c2_data_p1_q <= in_c2.data;
  end

  // ---- T1: relocation add on the live offset, drop decision ----
  always_comb begin
    c0_sum               = reloc(c0_hdr_p1_q.address, offset[41:0]);
    c0_carry             = c0_sum[42];
    c0_hdr_reloc         = c0_hdr_p1_q;
    c0_hdr_reloc.address = c0_sum[41:0];

    // Fences carry no meaningful address: never relocated, never overflow.
    c1_fence     = (c1_hdr_p1_q.req_type == eREQ_WRFENCE);
    c1_sum       = reloc(c1_hdr_p1_q.address, offset[41:0]);
    c1_carry     = c1_sum[42] & ~c1_fence;
    c1_hdr_reloc = c1_hdr_p1_q;
    if (!c1_fence) c1_hdr_reloc.address = c1_sum[41:0];

    // A request already dropped by hold is not also reported as overflow.
    c0_live  = c0_vld_p1_q & ~c0_drop_p1_q;
    c1_live  = c1_vld_p1_q & ~c1_drop_p1_q;
    c0_fwd   = c0_live & ~c0_carry;
    c1_fwd   = c1_live & ~c1_carry;
    c0_ovf   = c0_live & c0_carry;
    c1_ovf   = c1_live & c1_carry;
    c0_drop  = c0_vld_p1_q & ~c0_fwd;
    c1_drop  = c1_vld_p1_q & ~c1_fwd;
    drop_inc = {1'b0, c0_drop} + {1'b0, c1_drop};
  end

  // ---- T1 -> T2 ----
  always_ff @(posedge clk) begin
    if (reset) begin
      c0_vld_p2_q <= 1'b0;
      c1_vld_p2_q <= 1'b0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      c0_vld_p2_q <= c0_fwd;
      c1_vld_p2_q <= c1_fwd;
      cnt_q       <= sat_add(cnt_q, drop_inc);
      ovf_q       <= ovf_q | c0_ovf | c1_ovf;
    end
  end

  always_ff @(posedge clk) begin
    c0_hdr_p2_q  <= c0_hdr_reloc;
    c1_hdr_p2_q  <= c1_hdr_reloc;
    c1_data_p2_q <= c1_data_p1_q;
  end

  always_comb begin
    out_c0.hdr         = c0_hdr_p2_q;
    out_c0.valid       = c0_vld_p2_q;
    out_c1.hdr         = c1_hdr_p2_q;
    out_c1.data        = c1_data_p2_q;
    out_c1.valid       = c1_vld_p2_q;
    out_c2.hdr         = c2_hdr_p1_q;
    out_c2.mmioRdValid = c2_vld_p1_q;
    out_c2.data        = c2_data_p1_q;
  end

  assign drop_count = cnt_q;
  assign ovf_err    = ovf_q;
  assign vmid_out   = 8'(VMID);

endmodule

// File: tb/tb_vai_tx_auditor.sv
// Testbench for vai_tx_auditor: directed stimulus with a queue-based
// scoreboard per Tx channel and a monitor that checks outputs as they appear.
module tb_vai_tx_auditor;
  import vai_tx_auditor_pkg::*;

  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           sub_reset = 1'b0;
  logic [63:0]    offset = '0;
  t_if_ccip_c0_Tx in_c0, out_c0;
  t_if_ccip_c1_Tx in_c1, out_c1;
  t_if_ccip_c2_Tx in_c2, out_c2;
  logic [CW-1:0]  drop_count;
  logic           ovf_err;
  logic [7:0]     vmid_out;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct { int due; t_ccip_c0_ReqMemHdr hdr; } exp_c0_t;
  typedef struct { int due; t_ccip_c1_ReqMemHdr hdr; logic [511:0] data; } exp_c1_t;
  typedef struct { int due; t_ccip_c2_RspMmioHdr hdr; logic [63:0] data; } exp_c2_t;

  exp_c0_t q0[$];
  exp_c1_t q1[$];
  exp_c2_t q2[$];

  vai_tx_auditor #(.VMID(3), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .offset     (offset),
    .sub_reset  (sub_reset),
    .in_c0      (in_c0),
    .in_c1      (in_c1),
    .in_c2      (in_c2),
    .out_c0     (out_c0),
    .out_c1     (out_c1),
    .out_c2     (out_c2),
    .drop_count (drop_count),
    .ovf_err    (ovf_err),
    .vmid_out   (vmid_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: outputs are registered, so sampling on the falling edge is safe.
  always @(negedge clk) begin : monitor
    exp_c0_t e0;
    exp_c1_t e1;
    exp_c2_t e2;
    if (out_c0.valid && q0.size() == 0) begin
      chk("c0_unexpected_valid", 128'(out_c0.valid), 128'(1'b0));
    end else if (out_c0.valid) begin
      e0 = q0.pop_front();
      chk("c0_cycle", 128'(cyc), 128'(e0.due));
      chk("c0_hdr", 128'(out_c0.hdr), 128'(e0.hdr));
    end else if (q0.size() != 0 && q0[0].due <= cyc) begin
      e0 = q0.pop_front();
      chk("c0_missing_valid", 128'(out_c0.valid), 128'(1'b1));
    end

    if (out_c1.valid && q1.size() == 0) begin
      chk("c1_unexpected_valid", 128'(out_c1.valid), 128'(1'b0));
    end else if (out_c1.valid) begin
      e1 = q1.pop_front();
      chk("c1_cycle", 128'(cyc), 128'(e1.due));
      chk("c1_hdr", 128'(out_c1.hdr), 128'(e1.hdr));
      chk("c1_data_equal", 128'(out_c1.data == e1.data), 128'(1'b1));
    end else if (q1.size() != 0 && q1[0].due <= cyc) begin
      e1 = q1.pop_front();
      chk("c1_missing_valid", 128'(out_c1.valid), 128'(1'b1));
    end

    if (out_c2.mmioRdValid && q2.size() == 0) begin
      chk("c2_unexpected_valid", 128'(out_c2.mmioRdValid), 128'(1'b0));
    end else if (out_c2.mmioRdValid) begin
      e2 = q2.pop_front();
      chk("c2_cycle", 128'(cyc), 128'(e2.due));
      chk("c2_tid", 128'(out_c2.hdr), 128'(e2.hdr));
      chk("c2_data", 128'(out_c2.data), 128'(e2.data));
    end else if (q2.size() != 0 && q2[0].due <= cyc) begin
      e2 = q2.pop_front();
      chk("c2_missing_valid", 128'(out_c2.mmioRdValid), 128'(1'b1));
    end
  end

  // Advance n cycles; valids are cleared after the first edge.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_c0.valid        = 1'b0;
      in_c1.valid        = 1'b0;
      in_c2.mmioRdValid  = 1'b0;
    end
  endtask

  task automatic set_c0(input logic [41:0] addr, input logic [15:0] md,
                        input bit pass, input logic [41:0] exp_addr);
    exp_c0_t e;
    in_c0.hdr          = '0;
    in_c0.hdr.vc_sel   = 2'b10;
    in_c0.hdr.cl_len   = 2'b01;
    in_c0.hdr.req_type = eREQ_RDLINE_S;
    in_c0.hdr.address  = addr;
    in_c0.hdr.mdata    = md;
    in_c0.valid        = 1'b1;
    if (pass) begin
      e.due         = cyc + 2;
      e.hdr         = in_c0.hdr;
      e.hdr.address = exp_addr;
      q0.push_back(e);
    end
  endtask

  task automatic set_c1(input logic [41:0] addr, input logic [15:0] md,
                        input logic [3:0] rt, input logic sop, input logic [511:0] d,
                        input bit pass, input logic [41:0] exp_addr);
    exp_c1_t e;
    in_c1.hdr          = '0;
    in_c1.hdr.vc_sel   = 2'b01;
    in_c1.hdr.sop      = sop;
    in_c1.hdr.req_type = rt;
    in_c1.hdr.address  = addr;
    in_c1.hdr.mdata    = md;
    in_c1.data         = d;
    in_c1.valid        = 1'b1;
    if (pass) begin
      e.due         = cyc + 2;
      e.hdr         = in_c1.hdr;
      e.hdr.address = exp_addr;
      e.data        = d;
      q1.push_back(e);
    end
  endtask

  task automatic set_c2(input logic [8:0] tid, input logic [63:0] d);
    exp_c2_t e;
    in_c2.hdr.tid      = tid;
    in_c2.data         = d;
    in_c2.mmioRdValid  = 1'b1;
    e.due      = cyc + 1;
    e.hdr.tid  = tid;
    e.data     = d;
    q2.push_back(e);
  endtask

  logic [511:0] pat;

  initial begin
    in_c0 = '0;
    in_c1 = '0;
    in_c2 = '0;
    pat   = {8{64'h0123_4567_89AB_CDEF}};

    // Reset state
    idle(3);
    chk("rst_c0_valid", 128'(out_c0.valid), 128'(1'b0));
    chk("rst_c1_valid", 128'(out_c1.valid), 128'(1'b0));
    chk("rst_c2_valid", 128'(out_c2.mmioRdValid), 128'(1'b0));
    chk("rst_drop_count", 128'(drop_count), 128'(0));
    chk("rst_ovf_err", 128'(ovf_err), 128'(1'b0));
    chk("vmid_out", 128'(vmid_out), 128'(8'd3));
    reset = 1'b0;
    idle(2);

    // Basic relocation on c0 and c1 together, then c2 pass-through
    offset = 64'h100;
    set_c0(42'h2000, 16'hABCD, 1'b1, 42'h2100);
    set_c1(42'h5000, 16'h1234, eREQ_WRLINE_I, 1'b1, pat, 1'b1, 42'h5100);
    idle(1);
    set_c2(9'h1A3, 64'hDEAD_BEEF_CAFE_F00D);
    idle(1);
    // Offset changes while the request sits in T1: the new offset applies.
    set_c0(42'h10, 16'h0002, 1'b1, 42'h50);
    idle(1);
    offset = 64'h40;
    idle(4);
    chk("t1_drop_count", 128'(drop_count), 128'(0));
    chk("t1_ovf_err", 128'(ovf_err), 128'(1'b0));

    // Overflow drop on c1; c0 lands exactly on the top address
    offset = 64'h10;
    set_c1(42'h3FF_FFFF_FFF8, 16'h0BAD, eREQ_WRLINE_M, 1'b1, pat, 1'b0, '0);
    set_c0(42'h3FF_FFFF_FFEF, 16'h0003, 1'b1, 42'h3FF_FFFF_FFFF);
    idle(4);
    chk("ovf_err_set", 128'(ovf_err), 128'(1'b1));
    chk("ovf_drop_count", 128'(drop_count), 128'(1));

    // Fence exemption, overflow on a write, multi-beat relocation
    offset = 64'h3FF_FFFF_FFFF;
    set_c1(42'h1234, 16'h0005, eREQ_WRFENCE, 1'b1, '0, 1'b1, 42'h1234);
    idle(1);
    set_c1(42'h1, 16'h0006, eREQ_WRLINE_I, 1'b1, pat, 1'b0, '0);
    idle(2);
    offset = 64'h100;
    set_c1(42'h40, 16'h0007, eREQ_WRLINE_I, 1'b0, ~pat, 1'b1, 42'h140);
    idle(4);
    chk("fence_drop_count", 128'(drop_count), 128'(2));
    chk("fence_ovf_sticky", 128'(ovf_err), 128'(1'b1));

    // Reset clears counter and sticky flag
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
    chk("rst2_drop_count", 128'(drop_count), 128'(0));
    chk("rst2_ovf_err", 128'(ovf_err), 128'(1'b0));

    // HOLD: in-flight request completes, 5 held cycles drop 10, c2 forwarded
    set_c0(42'h100, 16'h0001, 1'b1, 42'h200);
    idle(1);
    for (int i = 0; i < 5; i++) begin
      sub_reset = 1'b1;
      set_c0(42'h800 + 42'(i), 16'h0010, 1'b0, '0);
      set_c1(42'h900, 16'h0020, eREQ_WRLINE_I, 1'b1, pat, 1'b0, '0);
      if (i == 2) set_c2(9'h055, 64'h1122_3344_5566_7788);
      idle(1);
    end
    sub_reset = 1'b0;
    set_c0(42'h300, 16'h0007, 1'b1, 42'h400);
    idle(5);
    chk("hold_drop_count", 128'(drop_count), 128'(10));
    chk("hold_ovf_err", 128'(ovf_err), 128'(1'b0));

    // Saturation of the 4-bit counter
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
    sub_reset = 1'b1;
    for (int i = 0; i < 14; i++) begin
      set_c0(42'h0, 16'h0000, 1'b0, '0);
      idle(1);
    end
    idle(3);
    chk("sat_count_14", 128'(drop_count), 128'(14));
    set_c0(42'h0, 16'h0000, 1'b0, '0);
    set_c1(42'h0, 16'h0000, eREQ_WRLINE_I, 1'b1, pat, 1'b0, '0);
    idle(4);
    chk("sat_dual_drop", 128'(drop_count), 128'(15));
    set_c0(42'h0, 16'h0000, 1'b0, '0);
    idle(4);
    chk("sat_hold_at_max", 128'(drop_count), 128'(15));
    sub_reset = 1'b0;
    idle(2);
    chk("sat_kept_after_sub_reset", 128'(drop_count), 128'(15));

    // Reset asserted one cycle after a request enters: no output
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    offset = 64'h10;
    set_c1(42'h3FF_FFFF_FFFF, 16'h0001, eREQ_WRLINE_I, 1'b1, pat, 1'b0, '0);
    idle(4);
    chk("pre_mid_ovf_err", 128'(ovf_err), 128'(1'b1));
    chk("pre_mid_drop_count", 128'(drop_count), 128'(1));
    set_c0(42'h2000, 16'h0009, 1'b0, '0);
    idle(1);
    reset = 1'b1;
    idle(1);
    chk("mid_reset_c0_valid", 128'(out_c0.valid), 128'(1'b0));
    reset = 1'b0;
    idle(1);
    chk("mid_reset_drop_count", 128'(drop_count), 128'(0));
    chk("mid_reset_ovf_err", 128'(ovf_err), 128'(1'b0));

    idle(3);
    chk("sb_c0_empty", 128'(q0.size()), 128'(0));
    chk("sb_c1_empty", 128'(q1.size()), 128'(0));
    chk("sb_c2_empty", 128'(q2.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
